// File: rtl/sound_ram_arbiter_if.sv
// Sound RAM port bundle: DOC fetch, GLU host access and the shared RAM side.
// Latency: none (wiring only).
// Backpressure: requests are levels held until the matching completion pulse.
interface sound_ram_arbiter_if;
    logic        doc_req;
    logic [15:0] doc_addr;
    logic [7:0]  doc_data;
    logic        doc_valid;
    logic        host_req;
    logic        host_wr;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata;
    logic [7:0]  host_rdata;
    logic        host_ack;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    modport slave (
        input  doc_req, doc_addr, host_req, host_wr, host_addr, host_wdata, ram_rdata,
        output doc_data, doc_valid, host_rdata, host_ack, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output doc_req, doc_addr, host_req, host_wr, host_addr, host_wdata, ram_rdata,
        input  doc_data, doc_valid, host_rdata, host_ack, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/sound_ram_arbiter.sv
// Sound RAM arbiter: DOC fetches have priority over GLU host accesses; SOUND_RAM_STARVE_GUARD_EN adds a host anti-starvation counter.
// Latency: reads complete 3 edges after the grant edge (counting it), writes on the grant edge itself.
// Backpressure: requests wait as held levels; arbitration only in IDLE on a clk_7M_en strobe.
module sound_ram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic               CLK_14M,
    input  logic               reset_n,
    input  logic               clk_7M_en,
    output logic               busy,
    sound_ram_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DOC_RD  = 2'd1;
    localparam logic [1:0] HOST_RD = 2'd2;
    localparam logic [1:0] HOST_WR = 2'd3;

    logic [1:0] state;
    logic       phase;
    logic       arb;
    logic       grant_doc;
    logic       grant_host;

    generate
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
            $error("STARVE_LIMIT must lie in 1..15");
        end
    endgenerate

    assign arb  = (state == IDLE) && clk_7M_en;
    assign busy = (state != IDLE);

`ifdef SOUND_RAM_STARVE_GUARD_EN
    logic [3:0] starve_cnt;
    logic       force_host;

    // Once the host has watched STARVE_LIMIT DOC grants go by, it wins the next slot.
    assign force_host = bus.host_req && (starve_cnt == 4'(STARVE_LIMIT));
    assign grant_doc  = arb && bus.doc_req && !force_host;

    always_ff @(posedge CLK_14M or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= 4'd0;
        end else if (grant_host) begin
            starve_cnt <= 4'd0;
        end else if (grant_doc) begin
            starve_cnt <= bus.host_req ? starve_cnt + 4'd1 : 4'd0;
        end
    end
`else
    assign grant_doc = arb && bus.doc_req;
`endif

    assign grant_host = arb && bus.host_req && !grant_doc;

    always_ff @(posedge CLK_14M or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            phase          <= 1'b0;
            bus.ram_addr   <= '0;
            bus.ram_wdata  <= '0;
            bus.ram_we     <= 1'b0;
            bus.doc_data   <= '0;
            bus.doc_valid  <= 1'b0;
            bus.host_rdata <= '0;
            bus.host_ack   <= 1'b0;
        end else begin
            bus.ram_we    <= 1'b0;
            bus.doc_valid <= 1'b0;
            bus.host_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    phase <= 1'b0;
                    if (grant_doc) begin
                        state        <= DOC_RD;
                        bus.ram_addr <= bus.doc_addr;
                    end else if (grant_host) begin
                        bus.ram_addr  <= bus.host_addr;
                        bus.ram_wdata <= bus.host_wdata;
                        if (bus.host_wr) begin
                            state        <= HOST_WR;
                            bus.ram_we   <= 1'b1;
                            bus.host_ack <= 1'b1;
                        end else begin
                            state <= HOST_RD;
                        end
                    end
                end
                DOC_RD, HOST_RD: begin
                    // Phase 0 covers the RAM's registered read; data is captured in phase 1.
                    phase <= ~phase;
                    if (phase) begin
                        state <= IDLE;
                        if (state == DOC_RD) begin
                            bus.doc_data  <= bus.ram_rdata;
                            bus.doc_valid <= 1'b1;
                        end else begin
                            bus.host_rdata <= bus.ram_rdata;
                            bus.host_ack   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sound_ram_arbiter.sv
// Bench for sound_ram_arbiter: cycle table, corner-case sequences and random traffic
// scored against a transaction-timeline reference.
module tb_sound_ram_arbiter;
    localparam int LIMIT = 4;
`ifdef SOUND_RAM_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic CLK_14M = 1'b0;
    logic reset_n;
    logic clk_7M_en;
    logic busy;

    sound_ram_arbiter_if bus();

    sound_ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK_14M   (CLK_14M),
        .reset_n   (reset_n),
        .clk_7M_en (clk_7M_en),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 CLK_14M = ~CLK_14M;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return (a == 16'h1234) ? 8'h5A : (a[7:0] ^ a[15:8]);
    endfunction

    // RAM with 1-cycle synchronous read
    logic [7:0] ram    [0:65535];
    bit         ram_wr [0:65535];
    always @(posedge CLK_14M) begin
        if (bus.ram_we) begin
            ram[bus.ram_addr]    <= bus.ram_wdata;
            ram_wr[bus.ram_addr] <= 1'b1;
        end
        bus.ram_rdata <= ram_wr[bus.ram_addr] ? ram[bus.ram_addr] : init_val(bus.ram_addr);
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    // Reference: each grant becomes a scheduled timeline of pulses and register values.
    logic [7:0]  mm    [0:65535];
    bit          mm_wr [0:65535];
    int          cyc, free_at, busy_lo, busy_hi, dv_at, ha_at, hr_at, we_at, starve;
    logic [7:0]  m_doc_data, m_host_rdata, pend_doc, pend_host, m_ram_wdata, pw_data;
    logic [15:0] m_ram_addr, pw_addr;
    bit          pw_valid;

    function automatic logic [7:0] mval(input logic [15:0] a);
        return mm_wr[a] ? mm[a] : init_val(a);
    endfunction

    task automatic model_reset();
        free_at = 0; busy_lo = -1; busy_hi = -2;
        dv_at = -1; ha_at = -1; hr_at = -1; we_at = -1; starve = 0;
        m_doc_data = 8'h00; m_host_rdata = 8'h00; m_ram_wdata = 8'h00; m_ram_addr = 16'h0000;
        pend_doc = 8'h00; pend_host = 8'h00; pw_valid = 1'b0;
    endtask

    task automatic step(input bit use_model);
        int e;
        bit to_host;
        e = cyc + 1;
        if (!reset_n) begin
            model_reset();
        end else begin
            if (pw_valid) begin
                mm[pw_addr] = pw_data; mm_wr[pw_addr] = 1'b1; pw_valid = 1'b0;
            end
            if (e >= free_at && clk_7M_en && (bus.doc_req || bus.host_req)) begin
                to_host = !bus.doc_req;
                if (GUARD && bus.doc_req && bus.host_req && starve == LIMIT) to_host = 1'b1;
                if (to_host) starve = 0;
                else         starve = bus.host_req ? starve + 1 : 0;
                if (!to_host) begin
                    m_ram_addr = bus.doc_addr; pend_doc = mval(bus.doc_addr);
                    dv_at = e + 2; busy_lo = e; busy_hi = e + 1; free_at = e + 3;
                end else begin
                    m_ram_addr = bus.host_addr; m_ram_wdata = bus.host_wdata;
                    if (bus.host_wr) begin
                        pw_valid = 1'b1; pw_addr = bus.host_addr; pw_data = bus.host_wdata;
                        we_at = e; ha_at = e; busy_lo = e; busy_hi = e; free_at = e + 2;
                    end else begin
                        pend_host = mval(bus.host_addr);
                        ha_at = e + 2; hr_at = e + 2; busy_lo = e; busy_hi = e + 1; free_at = e + 3;
                    end
                end
            end
        end
        @(posedge CLK_14M);
        cyc = e;
        if (cyc == dv_at) m_doc_data = pend_doc;
        if (cyc == hr_at) m_host_rdata = pend_host;
        #1;
        if (use_model) begin
            chk("m_busy",       32'(busy),           32'(cyc >= busy_lo && cyc <= busy_hi));
            chk("m_doc_valid",  32'(bus.doc_valid),  32'(cyc == dv_at));
            chk("m_host_ack",   32'(bus.host_ack),   32'(cyc == ha_at));
            chk("m_ram_we",     32'(bus.ram_we),     32'(cyc == we_at));
            chk("m_doc_data",   32'(bus.doc_data),   32'(m_doc_data));
            chk("m_host_rdata", 32'(bus.host_rdata), 32'(m_host_rdata));
            chk("m_ram_addr",   32'(bus.ram_addr),   32'(m_ram_addr));
            chk("m_ram_wdata",  32'(bus.ram_wdata),  32'(m_ram_wdata));
        end
    endtask

    function automatic logic [15:0] rand_addr();
        int r;
        r = $urandom_range(3);
        case (r)
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return {12'h000, 4'($urandom_range(15))};
            default: return 16'($urandom);
        endcase
    endfunction

    typedef struct {
        logic        en, dreq;
        logic [15:0] daddr;
        logic        hreq, hwr;
        logic [15:0] haddr;
        logic [7:0]  hwd;
        logic        busy, dv;
        logic [7:0]  dd;
        logic        ha;
        logic [7:0]  hr;
        logic        we;
        logic [15:0] ra;
    } vec_t;

    vec_t tbl [23];

    initial begin
        // Watchdog: the whole run is a few thousand cycles.
        #2000000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kinds[$];
        int n_host;

        //          en dreq daddr     hreq hwr haddr     hwd    busy dv dd     ha hr     we ra
        tbl[0]  = '{1, 1, 16'h1234, 0, 0, 16'h0000, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 16'h1234};
        tbl[1]  = '{0, 1, 16'h1234, 0, 0, 16'h0000, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 16'h1234};
        tbl[2]  = '{0, 1, 16'h1234, 0, 0, 16'h0000, 8'h00, 0, 1, 8'h5A, 0, 8'h00, 0, 16'h1234};
        tbl[3]  = '{1, 0, 16'h1234, 1, 1, 16'hFFFF, 8'hC3, 1, 0, 8'h5A, 1, 8'h00, 1, 16'hFFFF};
        tbl[4]  = '{0, 0, 16'h1234, 0, 1, 16'hFFFF, 8'hC3, 0, 0, 8'h5A, 0, 8'h00, 0, 16'hFFFF};
        tbl[5]  = '{1, 0, 16'h1234, 1, 0, 16'hFFFF, 8'h00, 1, 0, 8'h5A, 0, 8'h00, 0, 16'hFFFF};
        tbl[6]  = '{0, 0, 16'h1234, 1, 0, 16'hFFFF, 8'h00, 1, 0, 8'h5A, 0, 8'h00, 0, 16'hFFFF};
        tbl[7]  = '{0, 0, 16'h1234, 1, 0, 16'hFFFF, 8'h00, 0, 0, 8'h5A, 1, 8'hC3, 0, 16'hFFFF};
        tbl[8]  = '{1, 0, 16'h1234, 0, 0, 16'hFFFF, 8'h00, 0, 0, 8'h5A, 0, 8'hC3, 0, 16'hFFFF};
        tbl[9]  = '{1, 1, 16'h1234, 1, 0, 16'h1234, 8'h00, 1, 0, 8'h5A, 0, 8'hC3, 0, 16'h1234};
        tbl[10] = '{1, 1, 16'h1234, 1, 0, 16'h1234, 8'h00, 1, 0, 8'h5A, 0, 8'hC3, 0, 16'h1234};
        tbl[11] = '{1, 1, 16'h1234, 1, 0, 16'h1234, 8'h00, 0, 1, 8'h5A, 0, 8'hC3, 0, 16'h1234};
        tbl[12] = '{1, 0, 16'h1234, 1, 0, 16'h1234, 8'h00, 1, 0, 8'h5A, 0, 8'hC3, 0, 16'h1234};
        tbl[13] = '{0, 0, 16'h1234, 1, 0, 16'h1234, 8'h00, 1, 0, 8'h5A, 0, 8'hC3, 0, 16'h1234};
        tbl[14] = '{0, 0, 16'h1234, 1, 0, 16'h1234, 8'h00, 0, 0, 8'h5A, 1, 8'h5A, 0, 16'h1234};
        tbl[15] = '{0, 0, 16'h1234, 0, 0, 16'h1234, 8'h00, 0, 0, 8'h5A, 0, 8'h5A, 0, 16'h1234};
        tbl[16] = '{1, 1, 16'h8001, 0, 0, 16'h1234, 8'h00, 1, 0, 8'h5A, 0, 8'h5A, 0, 16'h8001};
        tbl[17] = '{1, 1, 16'h8001, 0, 0, 16'h1234, 8'h00, 1, 0, 8'h5A, 0, 8'h5A, 0, 16'h8001};
        tbl[18] = '{1, 1, 16'h8001, 0, 0, 16'h1234, 8'h00, 0, 1, 8'h81, 0, 8'h5A, 0, 16'h8001};
        tbl[19] = '{1, 1, 16'h8001, 0, 0, 16'h1234, 8'h00, 1, 0, 8'h81, 0, 8'h5A, 0, 16'h8001};
        tbl[20] = '{0, 0, 16'h8001, 0, 0, 16'h1234, 8'h00, 1, 0, 8'h81, 0, 8'h5A, 0, 16'h8001};
        tbl[21] = '{0, 0, 16'h8001, 0, 0, 16'h1234, 8'h00, 0, 1, 8'h81, 0, 8'h5A, 0, 16'h8001};
        tbl[22] = '{0, 0, 16'h8001, 0, 0, 16'h1234, 8'h00, 0, 0, 8'h81, 0, 8'h5A, 0, 16'h8001};

        reset_n = 1'b0; clk_7M_en = 1'b0;
        bus.doc_req = 1'b0; bus.doc_addr = 16'h0000;
        bus.host_req = 1'b0; bus.host_wr = 1'b0; bus.host_addr = 16'h0000; bus.host_wdata = 8'h00;
        cyc = 0;
        model_reset();

        // Reset state
        step(1);
        step(1);
        chk("rst_busy",       32'(busy),           32'h0);
        chk("rst_ram_we",     32'(bus.ram_we),     32'h0);
        chk("rst_doc_valid",  32'(bus.doc_valid),  32'h0);
        chk("rst_host_ack",   32'(bus.host_ack),   32'h0);
        chk("rst_doc_data",   32'(bus.doc_data),   32'h0);
        chk("rst_host_rdata", 32'(bus.host_rdata), 32'h0);
        chk("rst_ram_addr",   32'(bus.ram_addr),   32'h0);
        chk("rst_ram_wdata",  32'(bus.ram_wdata),  32'h0);
        reset_n = 1'b1;

        // Cycle table: DOC fetch, host write/read at 0xFFFF, simultaneous requests, held re-request
        for (int i = 0; i < 23; i++) begin
            clk_7M_en      = tbl[i].en;
            bus.doc_req    = tbl[i].dreq;  bus.doc_addr  = tbl[i].daddr;
            bus.host_req   = tbl[i].hreq;  bus.host_wr   = tbl[i].hwr;
            bus.host_addr  = tbl[i].haddr; bus.host_wdata = tbl[i].hwd;
            step(0);
            chk($sformatf("t%0d_busy", i),       32'(busy),           32'(tbl[i].busy));
            chk($sformatf("t%0d_doc_valid", i),  32'(bus.doc_valid),  32'(tbl[i].dv));
            chk($sformatf("t%0d_doc_data", i),   32'(bus.doc_data),   32'(tbl[i].dd));
            chk($sformatf("t%0d_host_ack", i),   32'(bus.host_ack),   32'(tbl[i].ha));
            chk($sformatf("t%0d_host_rdata", i), 32'(bus.host_rdata), 32'(tbl[i].hr));
            chk($sformatf("t%0d_ram_we", i),     32'(bus.ram_we),     32'(tbl[i].we));
            chk($sformatf("t%0d_ram_addr", i),   32'(bus.ram_addr),   32'(tbl[i].ra));
        end

        // Reset just ahead of a host write grant edge
        clk_7M_en = 1'b1; bus.doc_req = 1'b0;
        bus.host_req = 1'b1; bus.host_wr = 1'b1; bus.host_addr = 16'h0ABC; bus.host_wdata = 8'h77;
        reset_n = 1'b0;
        #1;
        chk("rstw_async_busy", 32'(busy),       32'h0);
        chk("rstw_async_we",   32'(bus.ram_we), 32'h0);
        step(1);
        chk("rstw_we",       32'(bus.ram_we),   32'h0);
        chk("rstw_ack",      32'(bus.host_ack), 32'h0);
        chk("rstw_ram_addr", 32'(bus.ram_addr), 32'h0);
        reset_n = 1'b1; bus.host_req = 1'b0;
        step(1);
        step(1);
        chk("rstw_no_write", 32'(ram_wr[16'h0ABC]), 32'h0);

        // Reset during the HOST_WR cycle itself
        bus.host_req = 1'b1; bus.host_addr = 16'h0ABD; bus.host_wdata = 8'h55;
        step(1);
        bus.host_req = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rstm_async_we",   32'(bus.ram_we),   32'h0);
        chk("rstm_async_ack",  32'(bus.host_ack), 32'h0);
        chk("rstm_async_busy", 32'(busy),         32'h0);
        step(1);
        reset_n = 1'b1;
        step(1);
        chk("rstm_no_write", 32'(ram_wr[16'h0ABD]), 32'h0);

        // Reset in the middle of a DOC read: no completion pulse afterwards
        bus.doc_req = 1'b1; bus.doc_addr = 16'h2222;
        step(1);
        bus.doc_req = 1'b0;
        step(1);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk($sformatf("rstr_no_valid%0d", i), 32'(bus.doc_valid), 32'h0);
        end

        // Both requesters held high with the strobe every cycle
        bus.doc_req = 1'b1; bus.doc_addr = 16'h4000;
        bus.host_req = 1'b1; bus.host_wr = 1'b0; bus.host_addr = 16'h4001;
        n_host = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (bus.doc_valid) kinds.push_back(0);
            if (bus.host_ack) begin kinds.push_back(1); n_host++; end
        end
        chk("starve_enough", 32'(kinds.size() >= 5), 32'h1);
        for (int i = 0; i < 5 && i < kinds.size(); i++)
            chk($sformatf("starve_grant%0d", i), 32'(kinds[i]), 32'(GUARD && i == 4));
        chk("starve_host_seen", 32'(n_host > 0), 32'(GUARD));
        bus.doc_req = 1'b0; bus.host_req = 1'b0;
        for (int i = 0; i < 4; i++) step(1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            clk_7M_en = 1'($urandom_range(1));
            if (!bus.doc_req) begin
                if ($urandom_range(3) == 0) begin bus.doc_req = 1'b1; bus.doc_addr = rand_addr(); end
            end else if (bus.doc_valid) begin
                bus.doc_req = 1'($urandom_range(1)); bus.doc_addr = rand_addr();
            end else if ($urandom_range(40) == 0) begin
                bus.doc_req = 1'b0;
            end
            if (!bus.host_req) begin
                if ($urandom_range(3) == 0) begin
                    bus.host_req = 1'b1; bus.host_wr = 1'($urandom_range(1));
                    bus.host_addr = rand_addr(); bus.host_wdata = 8'($urandom);
                end
            end else if (bus.host_ack) begin
                bus.host_req = 1'($urandom_range(1)); bus.host_wr = 1'($urandom_range(1));
                bus.host_addr = rand_addr(); bus.host_wdata = 8'($urandom);
            end else if ($urandom_range(40) == 0) begin
                bus.host_req = 1'b0;
            end
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(299) == 0) reset_n = 1'b0;
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sound_ram_arbiter.md
SOUND_RAM_ARBITER -- requirements
Module: sound_ram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive DOC grants with a host request pending before the host is forced (range 1..15).
REQ-002 SHALL have port CLK_14M  input  1  system clock; sole clock.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port clk_7M_en  input  1  arbitration strobe, one CLK_14M cycle wide.
REQ-005 SHALL have port doc_req  input  1  DOC sample fetch request, level, held until doc_valid.
REQ-006 SHALL have port doc_addr  input  16  DOC fetch address.
REQ-007 SHALL have port doc_data  output  8  fetched sample byte.
REQ-008 SHALL have port doc_valid  output  1  one-cycle pulse; doc_data valid.
REQ-009 SHALL have port host_req  input  1  GLU RAM access request, level, held until host_ack.
REQ-010 SHALL have port host_wr  input  1  1 = write, 0 = read; sampled at grant.
REQ-011 SHALL have port host_addr  input  16  GLU RAM address.
REQ-012 SHALL have port host_wdata  input  8  GLU write byte.
REQ-013 SHALL have port host_rdata  output  8  GLU read byte.
REQ-014 SHALL have port host_ack  output  1  one-cycle pulse; access complete.
REQ-015 SHALL have port ram_addr  output  16  registered RAM address.
REQ-016 SHALL have port ram_we  output  1  registered RAM write enable.
REQ-017 SHALL have port ram_wdata  output  8  registered RAM write data.
REQ-018 SHALL have port ram_rdata  input  8  RAM read data, 1-cycle synchronous read.
REQ-019 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-020 SHALL implement states IDLE, DOC_RD, HOST_RD and HOST_WR with a 1-bit phase counter.
REQ-021 SHALL arbitrate only in IDLE on a cycle with clk_7M_en=1; otherwise SHALL remain in IDLE.
REQ-022 SHALL grant DOC when doc_req=1, else host when host_req=1; simultaneous requests go to DOC unless REQ-036 forces host.
REQ-023 SHALL, at the grant edge, latch the winner's address (and host_wr, host_wdata) into ram_addr and ram_wdata.
REQ-024 DOC_RD SHALL last 2 cycles: phase 0 waits for RAM; at the phase 1 edge doc_data<=ram_rdata and doc_valid pulses for the next cycle; return to IDLE.
REQ-025 HOST_RD SHALL behave as DOC_RD, loading host_rdata and pulsing host_ack.
REQ-026 HOST_WR SHALL assert ram_we for exactly 1 cycle (the cycle after grant), pulse host_ack in that same cycle, and return to IDLE.
REQ-027 Latency SHALL be 3 CLK_14M edges from the grant edge to doc_valid/host_ack for reads, and 1 edge for writes.
REQ-028 ram_we SHALL never be 1 outside HOST_WR.
REQ-029 doc_data and host_rdata SHALL hold their value until the next read to the same port completes.
REQ-030 Requests dropped mid-operation SHALL NOT abort the operation; the completion pulse is still issued.
REQ-031 A request still high in the cycle after its completion pulse SHALL be treated as a new request at the next clk_7M_en.
REQ-032 The address range SHALL be the full 0x0000..0xFFFF with no wrap or masking.

Reset
REQ-033 reset_n=0 SHALL immediately force state IDLE, phase 0, and ram_addr, ram_wdata, doc_data and host_rdata to 0.
REQ-034 reset_n=0 SHALL immediately force ram_we, doc_valid, host_ack and busy to 0 and clear the starvation counter.
REQ-035 A reset asserted mid-operation SHALL abandon that operation with no completion pulse, and no write SHALL occur.

Configuration
REQ-036 With SOUND_RAM_STARVE_GUARD_EN defined, a 4-bit counter SHALL:
- increment on each DOC grant while host_req=1;
- clear on any host grant, or on a DOC grant with host_req=0;
- when the count equals STARVE_LIMIT, grant the host at the next arbitration even if doc_req=1.
REQ-037 Without SOUND_RAM_STARVE_GUARD_EN, DOC priority SHALL be strict and no counter logic SHALL be present.

Verification
REQ-038 Single DOC fetch: RAM[0x1234]=0x5A, doc_req at a clk_7M_en -> ram_addr=0x1234, doc_valid 3 edges later with doc_data=0x5A.
REQ-039 Host write then read: write 0xFFFF<=0xC3 -> one ram_we pulse and host_ack; then read 0xFFFF -> host_rdata=0xC3.
REQ-040 Simultaneous doc_req and host_req -> DOC served first, host served at the next clk_7M_en after doc_valid.
REQ-041 Guard on with STARVE_LIMIT=4, doc_req and host_req held high -> the 5th grant goes to host; without the macro, host is never granted.
REQ-042 reset_n low during the HOST_WR grant cycle -> ram_we stays 0, no host_ack, and all outputs are 0.
